// File: rtl/fft_ctrl_pkg.sv
// Shared constants for the FFT stream controller: FSM encodings, config word layout
// and the transform-size clamp helper.
package fft_ctrl_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CFG  = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    localparam int         NFFT_LSB    = 0;
    localparam int         FWD_INV_BIT = 8;
    localparam int         LANE_W      = 16;
    localparam logic [4:0] NFFT_MIN    = 5'd3;

    function automatic logic [4:0] clamp_nfft(input logic [4:0] nfft, input logic [4:0] nmax);
        logic [4:0] r;
        if (nfft < NFFT_MIN) begin
            r = NFFT_MIN;
        end else if (nfft > nmax) begin
            r = nmax;
        end else begin
            r = nfft;
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_in_fifo.sv
// Synchronous sample FIFO (2^AW x W) with occupancy counter; caller guarantees
// push only when not full (or popping) and pop only when not empty.
module fft_in_fifo #(
    parameter int W  = 14,
    parameter int AW = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wp_q;
    logic [AW-1:0] rp_q;
    logic [AW:0]   cnt_q;
    logic [AW:0]   cnt_d;

    // occupancy next-state
    always_comb begin
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // storage array, no reset needed
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wp_q] <= wdata;
        end
    end

    // pointers and counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q  <= {AW{1'b0}};
            rp_q  <= {AW{1'b0}};
            cnt_q <= {(AW+1){1'b0}};
        end else begin
            if (push) wp_q <= wp_q + AW'(1);
            if (pop)  rp_q <= rp_q + AW'(1);
            cnt_q <= cnt_d;
        end
    end

    assign rdata = mem_q[rp_q];
    assign full  = (cnt_q == (AW+1)'(DEPTH));
    assign empty = (cnt_q == {(AW+1){1'b0}});

endmodule

// File: rtl/fft_stream_ctrl.sv
// Front/back-end controller for the AXI-Stream FFT core: config handshake, input framing,
// output demux, frame counting and sticky errors. Optional FFT_MAG_EN adds dout_mag.
module fft_stream_ctrl
    import fft_ctrl_pkg::*;
#(
    parameter int DIN_W      = 14,
    parameter int DOUT_W     = 14,
    parameter int LOG2_N_MAX = 10,
    parameter int FIFO_AW    = 4
) (
    input  logic                  sclk,
    input  logic                  rst,
    input  logic [4:0]            cfg_nfft,
    input  logic                  cfg_fwd_inv,
    input  logic                  cfg_update,
    input  logic [DIN_W-1:0]      din,
    input  logic                  din_valid,
    output logic [15:0]           s_axis_config_tdata,
    output logic                  s_axis_config_tvalid,
    input  logic                  s_axis_config_tready,
    output logic [31:0]           s_axis_data_tdata,
    output logic                  s_axis_data_tvalid,
    input  logic                  s_axis_data_tready,
    output logic                  s_axis_data_tlast,
    input  logic [31:0]           m_axis_data_tdata,
    input  logic [23:0]           m_axis_data_tuser,
    input  logic                  m_axis_data_tvalid,
    input  logic                  m_axis_data_tlast,
    output logic                  m_axis_data_tready,
    input  logic                  event_tlast_unexpected,
    input  logic                  event_tlast_missing,
    input  logic                  event_fft_overflow,
`ifdef FFT_MAG_EN
    output logic [DOUT_W:0]       dout_mag,
`endif
    output logic [DOUT_W-1:0]     dout_re,
    output logic [DOUT_W-1:0]     dout_im,
    output logic [LOG2_N_MAX-1:0] dout_idx,
    output logic                  dout_valid,
    output logic                  dout_last,
    output logic [15:0]           frame_cnt,
    input  logic                  err_clr,
    output logic                  err_fifo_ovf,
    output logic                  err_tlast,
    output logic                  err_fft_ovf,
    output logic                  busy
);

    logic [1:0]            state_q, state_d;
    logic [4:0]            nfft_q, nfft_d, nfft_clamp_s;
    logic                  fwd_q, fwd_d;
    logic [LOG2_N_MAX-1:0] cnt_q, cnt_d, last_cnt_s;
    logic                  pending_q, pending_d, busy_q;
    logic                  push_s, pop_s, full_s, empty_s, hs_last_s, go_cfg_s;
    logic [DIN_W-1:0]      fifo_rdata_s;
    logic [15:0]           cfg_word_s, frame_cnt_q;
    logic                  err_fifo_ovf_q, err_tlast_q, err_fft_ovf_q;
    logic [DOUT_W-1:0]     re1_q, im1_q;
    logic [LOG2_N_MAX-1:0] idx1_q;
    logic                  vld1_q, last1_q;
    logic                  unused_s;

    fft_in_fifo #(.W(DIN_W), .AW(FIFO_AW)) u_fifo (
        .clk   (sclk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (din),
        .rdata (fifo_rdata_s),
        .full  (full_s),
        .empty (empty_s)
    );

    assign nfft_clamp_s = clamp_nfft(cfg_nfft, 5'(LOG2_N_MAX));

    // last sample index of a frame: 2^nfft - 1 as a thermometer mask
    always_comb begin
        last_cnt_s = {LOG2_N_MAX{1'b0}};
        for (int i = 0; i < LOG2_N_MAX; i++) begin
            last_cnt_s[i] = (i < int'(nfft_q));
        end
    end

    // config word built from the latched fields
    always_comb begin
        cfg_word_s = 16'h0000;
        cfg_word_s[NFFT_LSB +: 5] = nfft_q;
        cfg_word_s[FWD_INV_BIT]   = fwd_q;
    end

    assign s_axis_config_tdata  = cfg_word_s;
    assign s_axis_config_tvalid = (state_q == ST_CFG);
    assign s_axis_data_tvalid   = (state_q == ST_RUN) & ~empty_s;
    assign s_axis_data_tlast    = s_axis_data_tvalid & (cnt_q == last_cnt_s);
    assign s_axis_data_tdata    = s_axis_data_tvalid ?
                                  {{(2*LANE_W-DIN_W){1'b0}}, fifo_rdata_s} : {(2*LANE_W){1'b0}};
    assign pop_s     = s_axis_data_tvalid & s_axis_data_tready;
    assign hs_last_s = pop_s & (cnt_q == last_cnt_s);
    assign push_s    = din_valid & (~full_s | pop_s);
    // reconfigure only on a frame boundary so the core never sees a truncated frame
    assign go_cfg_s  = (state_q == ST_RUN) & pending_q &
                       (hs_last_s | ((cnt_q == {LOG2_N_MAX{1'b0}}) & ~pop_s));

    // sequencing FSM and sample counter next-state
    always_comb begin
        state_d   = state_q;
        nfft_d    = nfft_q;
        fwd_d     = fwd_q;
        cnt_d     = cnt_q;
        pending_d = pending_q | cfg_update;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_CFG;
                nfft_d  = nfft_clamp_s;
                fwd_d   = cfg_fwd_inv;
            end
            ST_CFG: begin
                if (s_axis_config_tready) begin
                    state_d = ST_RUN;
                    cnt_d   = {LOG2_N_MAX{1'b0}};
                end else begin
                    state_d = ST_CFG;
                end
            end
            ST_RUN: begin
                if (go_cfg_s) begin
                    state_d   = ST_CFG;
                    nfft_d    = nfft_clamp_s;
                    fwd_d     = cfg_fwd_inv;
                    cnt_d     = {LOG2_N_MAX{1'b0}};
                    pending_d = cfg_update;
                end else if (hs_last_s) begin
                    cnt_d = {LOG2_N_MAX{1'b0}};
                end else if (pop_s) begin
                    cnt_d = cnt_q + LOG2_N_MAX'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // control state, sticky errors, frame counter and first output stage
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            nfft_q         <= 5'd0;
            fwd_q          <= 1'b0;
            cnt_q          <= {LOG2_N_MAX{1'b0}};
            pending_q      <= 1'b0;
            busy_q         <= 1'b0;
            err_fifo_ovf_q <= 1'b0;
            err_tlast_q    <= 1'b0;
            err_fft_ovf_q  <= 1'b0;
            frame_cnt_q    <= 16'd0;
            re1_q          <= {DOUT_W{1'b0}};
            im1_q          <= {DOUT_W{1'b0}};
            idx1_q         <= {LOG2_N_MAX{1'b0}};
            vld1_q         <= 1'b0;
            last1_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            nfft_q         <= nfft_d;
            fwd_q          <= fwd_d;
            cnt_q          <= cnt_d;
            pending_q      <= pending_d;
            busy_q         <= (state_d != ST_RUN) | pending_d;
            err_fifo_ovf_q <= (err_fifo_ovf_q & ~err_clr) | (full_s & din_valid & ~pop_s);
            err_tlast_q    <= (err_tlast_q & ~err_clr) | event_tlast_unexpected | event_tlast_missing;
            err_fft_ovf_q  <= (err_fft_ovf_q & ~err_clr) | event_fft_overflow;
            if (m_axis_data_tvalid & m_axis_data_tlast) frame_cnt_q <= frame_cnt_q + 16'd1;
            vld1_q  <= m_axis_data_tvalid;
            last1_q <= m_axis_data_tvalid & m_axis_data_tlast;
            if (m_axis_data_tvalid) begin
                re1_q  <= m_axis_data_tdata[DOUT_W-1:0];
                im1_q  <= m_axis_data_tdata[LANE_W +: DOUT_W];
                idx1_q <= m_axis_data_tuser[LOG2_N_MAX-1:0];
            end
        end
    end

`ifdef FFT_MAG_EN
    logic [DOUT_W-1:0]     re2_q, im2_q;
    logic [LOG2_N_MAX-1:0] idx2_q;
    logic                  vld2_q, last2_q;
    logic [DOUT_W:0]       mag_q;

    function automatic logic [DOUT_W-1:0] abs_lane(input logic [DOUT_W-1:0] x);
        logic [DOUT_W-1:0] r;
        if (x[DOUT_W-1]) begin
            r = ~x + DOUT_W'(1);
        end else begin
            r = x;
        end
        return r;
    endfunction

    // second stage computes |re|+|im| and keeps every dout_* aligned with it
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            re2_q   <= {DOUT_W{1'b0}};
            im2_q   <= {DOUT_W{1'b0}};
            idx2_q  <= {LOG2_N_MAX{1'b0}};
            vld2_q  <= 1'b0;
            last2_q <= 1'b0;
            mag_q   <= {(DOUT_W+1){1'b0}};
        end else begin
            vld2_q  <= vld1_q;
            last2_q <= last1_q;
            if (vld1_q) begin
                re2_q  <= re1_q;
                im2_q  <= im1_q;
                idx2_q <= idx1_q;
                mag_q  <= {1'b0, abs_lane(re1_q)} + {1'b0, abs_lane(im1_q)};
            end
        end
    end

    assign dout_re    = re2_q;
    assign dout_im    = im2_q;
    assign dout_idx   = idx2_q;
    assign dout_valid = vld2_q;
    assign dout_last  = last2_q;
    assign dout_mag   = mag_q;
`else
    assign dout_re    = re1_q;
    assign dout_im    = im1_q;
    assign dout_idx   = idx1_q;
    assign dout_valid = vld1_q;
    assign dout_last  = last1_q;
`endif

    assign m_axis_data_tready = 1'b1;
    assign frame_cnt    = frame_cnt_q;
    assign err_fifo_ovf = err_fifo_ovf_q;
    assign err_tlast    = err_tlast_q;
    assign err_fft_ovf  = err_fft_ovf_q;
    assign busy         = busy_q;
    assign unused_s     = ^{m_axis_data_tdata, m_axis_data_tuser};

endmodule

// File: tb/tb_fft_stream_ctrl.sv
// Directed self-checking bench for fft_stream_ctrl (default build, FFT_MAG_EN undefined).
module tb_fft_stream_ctrl;

    logic        sclk = 1'b0;
    logic        rst;
    logic [4:0]  cfg_nfft;
    logic        cfg_fwd_inv, cfg_update;
    logic [13:0] din;
    logic        din_valid;
    logic [15:0] s_axis_config_tdata;
    logic        s_axis_config_tvalid, s_axis_config_tready;
    logic [31:0] s_axis_data_tdata;
    logic        s_axis_data_tvalid, s_axis_data_tready, s_axis_data_tlast;
    logic [31:0] m_axis_data_tdata;
    logic [23:0] m_axis_data_tuser;
    logic        m_axis_data_tvalid, m_axis_data_tlast, m_axis_data_tready;
    logic        event_tlast_unexpected, event_tlast_missing, event_fft_overflow;
    logic [13:0] dout_re, dout_im;
    logic [9:0]  dout_idx;
    logic        dout_valid, dout_last;
    logic [15:0] frame_cnt;
    logic        err_clr, err_fifo_ovf, err_tlast, err_fft_ovf, busy;
`ifdef FFT_MAG_EN
    logic [14:0] dout_mag;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 sclk = ~sclk;

    fft_stream_ctrl dut (
        .sclk                   (sclk),
        .rst                    (rst),
        .cfg_nfft               (cfg_nfft),
        .cfg_fwd_inv            (cfg_fwd_inv),
        .cfg_update             (cfg_update),
        .din                    (din),
        .din_valid              (din_valid),
        .s_axis_config_tdata    (s_axis_config_tdata),
        .s_axis_config_tvalid   (s_axis_config_tvalid),
        .s_axis_config_tready   (s_axis_config_tready),
        .s_axis_data_tdata      (s_axis_data_tdata),
        .s_axis_data_tvalid     (s_axis_data_tvalid),
        .s_axis_data_tready     (s_axis_data_tready),
        .s_axis_data_tlast      (s_axis_data_tlast),
        .m_axis_data_tdata      (m_axis_data_tdata),
        .m_axis_data_tuser      (m_axis_data_tuser),
        .m_axis_data_tvalid     (m_axis_data_tvalid),
        .m_axis_data_tlast      (m_axis_data_tlast),
        .m_axis_data_tready     (m_axis_data_tready),
        .event_tlast_unexpected (event_tlast_unexpected),
        .event_tlast_missing    (event_tlast_missing),
        .event_fft_overflow     (event_fft_overflow),
`ifdef FFT_MAG_EN
        .dout_mag               (dout_mag),
`endif
        .dout_re                (dout_re),
        .dout_im                (dout_im),
        .dout_idx               (dout_idx),
        .dout_valid             (dout_valid),
        .dout_last              (dout_last),
        .frame_cnt              (frame_cnt),
        .err_clr                (err_clr),
        .err_fifo_ovf           (err_fifo_ovf),
        .err_tlast              (err_tlast),
        .err_fft_ovf            (err_fft_ovf),
        .busy                   (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge sclk);
        #1;
    endtask

    initial begin
        int k, tl, ncfg;
        rst = 1'b1; cfg_nfft = 5'd3; cfg_fwd_inv = 1'b1; cfg_update = 1'b0;
        din = 14'd0; din_valid = 1'b0;
        s_axis_config_tready = 1'b0; s_axis_data_tready = 1'b0;
        m_axis_data_tdata = 32'd0; m_axis_data_tuser = 24'd0;
        m_axis_data_tvalid = 1'b0; m_axis_data_tlast = 1'b0;
        event_tlast_unexpected = 1'b0; event_tlast_missing = 1'b0; event_fft_overflow = 1'b0;
        err_clr = 1'b0;

        tick; tick;
        chk("rst_cfg_valid", 32'(s_axis_config_tvalid), 32'd0);
        chk("rst_cfg_tdata", 32'(s_axis_config_tdata), 32'd0);
        chk("rst_data_valid", 32'(s_axis_data_tvalid), 32'd0);
        chk("rst_dout_valid", 32'(dout_valid), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_errs", 32'({err_fifo_ovf, err_tlast, err_fft_ovf}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // bring-up: IDLE -> CFG, hold until tready
        rst = 1'b0;
        tick;
        chk("cfg_valid", 32'(s_axis_config_tvalid), 32'd1);
        chk("cfg_tdata", 32'(s_axis_config_tdata), 32'h0103);
        chk("cfg_busy", 32'(busy), 32'd1);
        tick;
        chk("cfg_hold_valid", 32'(s_axis_config_tvalid), 32'd1);
        chk("cfg_hold_tdata", 32'(s_axis_config_tdata), 32'h0103);
        s_axis_config_tready = 1'b1;
        tick;
        s_axis_config_tready = 1'b0;
        chk("run_cfg_valid", 32'(s_axis_config_tvalid), 32'd0);
        chk("run_busy", 32'(busy), 32'd0);

        // continuous stream 0..15, frames of 8
        s_axis_data_tready = 1'b1; k = 0; tl = 0;
        for (int c = 0; c < 20; c++) begin
            din_valid = (c < 16); din = 14'(c);
            tick;
            if (s_axis_data_tvalid) begin
                chk("stream_data", s_axis_data_tdata, 32'(k));
                chk("stream_tlast", 32'(s_axis_data_tlast), 32'(k % 8 == 7));
                if (s_axis_data_tlast) tl++;
                k++;
            end
        end
        chk("stream_count", 32'(k), 32'd16);
        chk("stream_tlast_count", 32'(tl), 32'd2);
        chk("stream_no_recfg", 32'(s_axis_config_tvalid), 32'd0);

        // FIFO overflow with tready held low
        s_axis_data_tready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            din_valid = 1'b1; din = 14'(100 + c);
            tick;
            if (c == 15) chk("ovf_not_yet", 32'(err_fifo_ovf), 32'd0);
        end
        chk("ovf_set", 32'(err_fifo_ovf), 32'd1);
        chk("ovf_head", s_axis_data_tdata, 32'd100);
        din_valid = 1'b0; err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
        chk("ovf_clr", 32'(err_fifo_ovf), 32'd0);

        // drain the 16 stored samples
        s_axis_data_tready = 1'b1; k = 0; tl = 0;
        for (int c = 0; c < 20; c++) begin
            if (s_axis_data_tvalid) begin
                chk("drain_data", s_axis_data_tdata, 32'(100 + k));
                chk("drain_tlast", 32'(s_axis_data_tlast), 32'(k % 8 == 7));
                if (s_axis_data_tlast) tl++;
                k++;
            end
            tick;
        end
        chk("drain_count", 32'(k), 32'd16);
        chk("drain_tlast_count", 32'(tl), 32'd2);

        // cfg_update at cnt=3, nfft 3 -> 4: reissue only after tlast
        s_axis_config_tready = 1'b1; k = 0; tl = 0; ncfg = 0;
        din_valid = 1'b1; din = 14'd300;
        for (int c = 0; c < 40; c++) begin
            tick;
            cfg_update = 1'b0;
            if (s_axis_config_tvalid) begin
                ncfg++;
                chk("upd_cfg_tdata", 32'(s_axis_config_tdata), 32'h0104);
                chk("upd_cfg_after_tlast", 32'(k), 32'd8);
            end
            if (s_axis_data_tvalid) begin
                chk("upd_data", s_axis_data_tdata, 32'(300 + k));
                chk("upd_tlast", 32'(s_axis_data_tlast), 32'((k == 7) || (k == 23)));
                if (s_axis_data_tlast) tl++;
                k++;
                if (k == 3) begin
                    cfg_update = 1'b1;
                    cfg_nfft = 5'd4;
                end
            end
            din_valid = (c + 1 < 30); din = 14'(301 + c);
        end
        s_axis_config_tready = 1'b0;
        chk("upd_count", 32'(k), 32'd30);
        chk("upd_tlast_count", 32'(tl), 32'd2);
        chk("upd_cfg_count", 32'(ncfg), 32'd1);
        chk("upd_busy_done", 32'(busy), 32'd0);

        // output path, latency 1
        m_axis_data_tvalid = 1'b1; m_axis_data_tdata = 32'h0005_3FFF;
        m_axis_data_tuser = 24'd7; m_axis_data_tlast = 1'b1;
        tick;
        m_axis_data_tvalid = 1'b0; m_axis_data_tlast = 1'b0;
        chk("out_re", 32'(dout_re), 32'h3FFF);
        chk("out_im", 32'(dout_im), 32'h0005);
        chk("out_idx", 32'(dout_idx), 32'd7);
        chk("out_valid", 32'(dout_valid), 32'd1);
        chk("out_last", 32'(dout_last), 32'd1);
        chk("out_frame_cnt", 32'(frame_cnt), 32'd1);
        chk("out_tready", 32'(m_axis_data_tready), 32'd1);
        tick;
        chk("out_idle_valid", 32'(dout_valid), 32'd0);
        chk("out_idle_frame_cnt", 32'(frame_cnt), 32'd1);
        m_axis_data_tvalid = 1'b1; m_axis_data_tdata = 32'h1234_0ABC; m_axis_data_tuser = 24'h000155;
        tick;
        m_axis_data_tvalid = 1'b0;
        chk("out2_re", 32'(dout_re), 32'h0ABC);
        chk("out2_im", 32'(dout_im), 32'h1234);
        chk("out2_idx", 32'(dout_idx), 32'h155);
        chk("out2_last", 32'(dout_last), 32'd0);
        chk("out2_frame_cnt", 32'(frame_cnt), 32'd1);

        // sticky errors, set wins over clear
        event_tlast_unexpected = 1'b1;
        tick;
        event_tlast_unexpected = 1'b0;
        chk("err_tlast_set", 32'(err_tlast), 32'd1);
        chk("err_fft_quiet", 32'(err_fft_ovf), 32'd0);
        event_fft_overflow = 1'b1;
        tick;
        event_fft_overflow = 1'b0;
        chk("err_fft_set", 32'(err_fft_ovf), 32'd1);
        err_clr = 1'b1; event_tlast_missing = 1'b1;
        tick;
        err_clr = 1'b0; event_tlast_missing = 1'b0;
        chk("err_tlast_set_wins", 32'(err_tlast), 32'd1);
        chk("err_fft_cleared", 32'(err_fft_ovf), 32'd0);
        err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
        chk("err_tlast_cleared", 32'(err_tlast), 32'd0);

        // advance cnt from 6 to 5 (wrap at 15 with nfft=4)
        s_axis_data_tready = 1'b1; k = 0;
        din_valid = 1'b1; din = 14'd500;
        for (int c = 0; c < 20; c++) begin
            tick;
            if (s_axis_data_tvalid) begin
                chk("pre_rst_data", s_axis_data_tdata, 32'(500 + k));
                chk("pre_rst_tlast", 32'(s_axis_data_tlast), 32'(k == 9));
                k++;
            end
            din_valid = (c + 1 < 15); din = 14'(501 + c);
        end
        chk("pre_rst_count", 32'(k), 32'd15);
        s_axis_data_tready = 1'b0; din_valid = 1'b1; din = 14'd600;
        tick; tick;
        din_valid = 1'b0;
        chk("pre_rst_valid", 32'(s_axis_data_tvalid), 32'd1);

        // reset mid-frame at cnt=5
        cfg_nfft = 5'd1; cfg_fwd_inv = 1'b0;
        rst = 1'b1;
        #2;
        chk("mid_rst_data_valid", 32'(s_axis_data_tvalid), 32'd0);
        chk("mid_rst_tdata", s_axis_data_tdata, 32'd0);
        chk("mid_rst_cfg_valid", 32'(s_axis_config_tvalid), 32'd0);
        chk("mid_rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("mid_rst_dout", 32'({dout_valid, dout_re}), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        tick;
        rst = 1'b0;
        tick;
        chk("post_rst_cfg_valid", 32'(s_axis_config_tvalid), 32'd1);
        chk("post_rst_cfg_clamp", 32'(s_axis_config_tdata), 32'h0003);
        chk("post_rst_fifo_empty", 32'(s_axis_data_tvalid), 32'd0);
        s_axis_config_tready = 1'b1;
        tick;
        s_axis_config_tready = 1'b0;
        s_axis_data_tready = 1'b1; k = 0; tl = 0;
        din_valid = 1'b1; din = 14'd700;
        for (int c = 0; c < 12; c++) begin
            tick;
            if (s_axis_data_tvalid) begin
                chk("post_rst_data", s_axis_data_tdata, 32'(700 + k));
                chk("post_rst_tlast", 32'(s_axis_data_tlast), 32'(k == 7));
                if (s_axis_data_tlast) tl++;
                k++;
            end
            din_valid = (c + 1 < 8); din = 14'(701 + c);
        end
        chk("post_rst_count", 32'(k), 32'd8);
        chk("post_rst_tlast_count", 32'(tl), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
